// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store initiator driving a word-wide data memory.
// Ports: cpu* = pipeline request/result, stall/accessErr = status, mem* = memory handshake.
module mem_access_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cpuRead,
   input  logic        cpuWrite,
   input  logic [1:0]  cpuSize,
   input  logic        cpuSigned,
   input  logic [31:0] cpuAddr,
   input  logic [31:0] cpuWriteData,
   output logic [31:0] cpuReadData,
   output logic        stall,
   output logic        accessErr,
   output logic [31:0] memAddr,
   output logic [31:0] memWriteData,
   output logic        memRead,
   output logic        memWrite,
   input  logic        memReady,
   input  logic [31:0] memReadData
);
   typedef enum logic [2:0] {
      S_IDLE, S_READ, S_WRITE,
      S_RMW_READ, S_RMW_WRITE, S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  lane_q, lane_d;
   logic [1:0]  size_q, size_d;
   logic        sgn_q, sgn_d;
   logic [15:0] wdat_q, wdat_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] maddr_q, maddr_d;
   logic [31:0] mwdata_q, mwdata_d;
   logic        err_q, err_d;

   logic        req, illegal;
   logic [31:0] shifted, ext, lmask, merged;

   assign req = cpuRead | cpuWrite;

   always_comb begin
      illegal = (cpuRead & cpuWrite)
              | (cpuSize == 2'b11)
              | ((cpuSize == 2'b01) & cpuAddr[0])
              | ((cpuSize == 2'b10) & (cpuAddr[1:0] != 2'b00));
   end

   // Alignment guarantees the lane shift also works for halves and words.
   always_comb begin
      shifted = memReadData >> {lane_q, 3'b000};
      unique case (size_q)
         2'b00:   ext = {{24{sgn_q & shifted[7]}}, shifted[7:0]};
         2'b01:   ext = {{16{sgn_q & shifted[15]}}, shifted[15:0]};
         default: ext = shifted;
      endcase
      lmask = ((size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF)
              << {lane_q, 3'b000};
      merged = (memReadData & ~lmask)
             | (({16'h0000, wdat_q} << {lane_q, 3'b000}) & lmask);
   end

   always_comb begin
      state_d  = state_q;
      lane_d   = lane_q;
      size_d   = size_q;
      sgn_d    = sgn_q;
      wdat_d   = wdat_q;
      rdata_d  = rdata_q;
      maddr_d  = maddr_q;
      mwdata_d = mwdata_q;
      err_d    = 1'b0;
      stall    = 1'b0;
      memRead  = 1'b0;
      memWrite = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (req && illegal) begin
               err_d = 1'b1;
            end else if (req) begin
               stall   = 1'b1;
               lane_d  = cpuAddr[1:0];
               size_d  = cpuSize;
               sgn_d   = cpuSigned;
               wdat_d  = cpuWriteData[15:0];
               maddr_d = {2'b00, cpuAddr[31:2]};
               if (cpuRead) begin
                  state_d = S_READ;
               end else if (cpuSize == 2'b10) begin
                  mwdata_d = cpuWriteData;
                  state_d  = S_WRITE;
               end else begin
                  state_d = S_RMW_READ;
               end
            end
         end
         S_READ: begin
            stall   = 1'b1;
            memRead = 1'b1;
            if (memReady) begin
               rdata_d = ext;
               state_d = S_DONE;
            end
         end
         S_RMW_READ: begin
            stall   = 1'b1;
            memRead = 1'b1;
            if (memReady) begin
               mwdata_d = merged;
               state_d  = S_RMW_WRITE;
            end
         end
         S_WRITE, S_RMW_WRITE: begin
            stall    = 1'b1;
            memWrite = 1'b1;
            if (memReady) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // A request seen during reset must not hold the pipeline.
      stall = stall & rst_n;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         lane_q   <= 2'b00;
         size_q   <= 2'b00;
         sgn_q    <= 1'b0;
         wdat_q   <= 16'h0000;
         rdata_q  <= 32'h0;
         maddr_q  <= 32'h0;
         mwdata_q <= 32'h0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         lane_q   <= lane_d;
         size_q   <= size_d;
         sgn_q    <= sgn_d;
         wdat_q   <= wdat_d;
         rdata_q  <= rdata_d;
         maddr_q  <= maddr_d;
         mwdata_q <= mwdata_d;
         err_q    <= err_d;
      end
   end

   assign cpuReadData  = rdata_q;
   assign accessErr    = err_q;
   assign memAddr      = maddr_q;
   assign memWriteData = mwdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: random and directed checks of mem_access_unit
// against a byte-array memory model.
module tb_mem_access_unit;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cpuRead = 1'b0, cpuWrite = 1'b0;
   logic [1:0]  cpuSize = 2'b00;
   logic        cpuSigned = 1'b0;
   logic [31:0] cpuAddr = '0, cpuWriteData = '0;
   logic [31:0] cpuReadData, memAddr, memWriteData, memReadData;
   logic        stall, accessErr, memRead, memWrite;
   logic        memReady = 1'b0;

   logic [31:0] mem [16];
   logic [7:0]  refb [64];
   int ntests = 0, nfail = 0;

   logic [31:0] obs_raddr, obs_wdata;
   int          obs_rcyc;
   bit          proto_bad;

   always #5 clk = ~clk;

   assign memReadData = mem[memAddr[3:0]];

   mem_access_unit dut (
      .clk(clk), .rst_n(rst_n),
      .cpuRead(cpuRead), .cpuWrite(cpuWrite),
      .cpuSize(cpuSize), .cpuSigned(cpuSigned),
      .cpuAddr(cpuAddr), .cpuWriteData(cpuWriteData),
      .cpuReadData(cpuReadData), .stall(stall),
      .accessErr(accessErr), .memAddr(memAddr),
      .memWriteData(memWriteData), .memRead(memRead),
      .memWrite(memWrite), .memReady(memReady),
      .memReadData(memReadData)
   );

   task automatic set_word(input int i, input logic [31:0] w);
      mem[i] = w;
      for (int k = 0; k < 4; k++) refb[4*i+k] = 8'(w >> (8*k));
   endtask

   function automatic logic [31:0] ref_word(input int i);
      return {refb[4*i+3], refb[4*i+2], refb[4*i+1], refb[4*i]};
   endfunction

   function automatic logic [31:0] ref_load(input logic [1:0] sz,
         input logic sg, input logic [31:0] a);
      longint v = 0;
      int n = 1 << sz;
      for (int k = n - 1; k >= 0; k--) v = v * 256 + refb[a[5:0] + k];
      if (sg && n < 4 && v >= (longint'(1) << (8*n - 1)))
         v = v - (longint'(1) << (8*n));
      return 32'(v);
   endfunction

   task automatic ref_store(input logic [1:0] sz, input logic [31:0] a,
         input logic [31:0] d);
      for (int k = 0; k < (1 << sz); k++) refb[a[5:0] + k] = 8'(d >> (8*k));
   endtask

   // One request; low_n >= 0 holds memReady low for cycles 1..low_n,
   // otherwise memReady is random with probability pct.
   task automatic access(input logic rd, input logic wr,
         input logic [1:0] sz, input logic sg,
         input logic [31:0] ad, input logic [31:0] wd,
         input int low_n, input int pct, input bit scr,
         output int st, output int lows, output logic [31:0] rdat);
      logic [31:0] ha, hd;
      bit hv, fin;
      @(negedge clk);
      cpuRead = rd; cpuWrite = wr; cpuSize = sz; cpuSigned = sg;
      cpuAddr = ad; cpuWriteData = wd;
      memReady = (low_n >= 0) ? 1'b0 : (int'($urandom_range(99)) < pct);
      st = 0; lows = 0; fin = 0; hv = 0; ha = 0; hd = 0;
      obs_rcyc = 0; obs_raddr = '1; obs_wdata = '1; proto_bad = 0;
      for (int c = 0; c < 200 && !fin; c++) begin
         #1;
         if (!stall) begin
            fin = 1;
            if (memRead || memWrite) proto_bad = 1;
         end else begin
            st++;
            if (c > 0 && !memReady) lows++;
            if (memRead && memWrite) proto_bad = 1;
            if (c > 0 && !(memRead || memWrite)) proto_bad = 1;
            if (hv && (memAddr !== ha || memWriteData !== hd)) proto_bad = 1;
            hv = (memRead || memWrite) && !memReady;
            ha = memAddr; hd = memWriteData;
            if (memRead) begin
               if (obs_rcyc == 0) obs_raddr = memAddr;
               obs_rcyc++;
            end
            if (memWrite && memReady) begin
               obs_wdata = memWriteData;
               mem[memAddr[3:0]] = memWriteData;
            end
            @(negedge clk);
            if (low_n >= 0) memReady = (c + 1 > low_n);
            else memReady = (int'($urandom_range(99)) < pct);
            if (scr) begin
               cpuAddr = $urandom; cpuSize = 2'($urandom);
               cpuWriteData = $urandom; cpuSigned = 1'($urandom);
            end
         end
      end
      ntests++;
      if (!fin) begin
         nfail++;
         $display("FAIL timeout: stall still %b after 200 cycles", stall);
      end
      rdat = cpuReadData;
      cpuRead = 0; cpuWrite = 0; memReady = 0;
   endtask

   task automatic test_reset();
      rst_n = 0; cpuRead = 1; cpuSize = 2'b10;
      repeat (2) @(negedge clk);
      #1;
      ntests++;
      if ({cpuReadData, memAddr, memWriteData} !== 96'h0 ||
          {memRead, memWrite, accessErr, stall} !== 4'b0) begin
         nfail++;
         $display("FAIL reset: rd=%h ad=%h wd=%h ctl=%b want 0",
            cpuReadData, memAddr, memWriteData,
            {memRead, memWrite, accessErr, stall});
      end
      cpuRead = 0;
      @(negedge clk); rst_n = 1;
   endtask

   task automatic test_word_load();
      int st, lw; logic [31:0] r;
      set_word(7, 32'h0000_0015);
      access(1, 0, 2'b10, 0, 32'h1C, 0, 0, 0, 0, st, lw, r);
      ntests++;
      if (r !== 32'h15 || st != 2 || obs_raddr !== 7 ||
          obs_rcyc != 1 || proto_bad) begin
         nfail++;
         $display("FAIL lw: data=%h st=%0d idx=%0d rc=%0d p=%b want 15/2/7/1/0",
            r, st, obs_raddr, obs_rcyc, proto_bad);
      end
   endtask

   task automatic test_subword_loads();
      int st, lw; logic [31:0] r;
      logic [1:0]  sz [3] = '{2'b00, 2'b00, 2'b01};
      logic        sg [3] = '{1'b1, 1'b0, 1'b1};
      logic [31:0] ad [3] = '{32'h1D, 32'h1D, 32'h1E};
      logic [31:0] ex [3] = '{32'hFFFF_FF80, 32'h80, 32'h1234};
      set_word(7, 32'h1234_80FF);
      for (int i = 0; i < 3; i++) begin
         access(1, 0, sz[i], sg[i], ad[i], 0, 0, 0, 0, st, lw, r);
         ntests++;
         if (r !== ex[i] || st != 2) begin
            nfail++;
            $display("FAIL subload%0d: got %h st=%0d want %h st=2",
               i, r, st, ex[i]);
         end
      end
   endtask

   task automatic test_sb();
      int st, lw; logic [31:0] r;
      set_word(1, 32'h0000_0005);
      access(0, 1, 2'b00, 0, 32'h05, 32'h0000_00AB, 0, 0, 0, st, lw, r);
      ref_store(2'b00, 32'h05, 32'hAB);
      ntests++;
      if (obs_raddr !== 1 || obs_wdata !== 32'h0000_AB05 || st != 3 ||
          mem[1] !== 32'h0000_AB05 || proto_bad) begin
         nfail++;
         $display("FAIL sb: idx=%0d wd=%h st=%0d p=%b want 1/0000ab05/3/0",
            obs_raddr, obs_wdata, st, proto_bad);
      end
   endtask

   task automatic test_ready_wait();
      int st, lw; logic [31:0] r;
      set_word(7, 32'hCAFE_F00D);
      access(1, 0, 2'b10, 0, 32'h1C, 0, 4, 0, 1, st, lw, r);
      ntests++;
      if (r !== 32'hCAFE_F00D || st != 6 || obs_rcyc != 5 || proto_bad) begin
         nfail++;
         $display("FAIL wait: data=%h st=%0d rc=%0d p=%b want cafef00d/6/5/0",
            r, st, obs_rcyc, proto_bad);
      end
   endtask

   task automatic test_illegal();
      logic [31:0] prev;
      logic        rd [4] = '{1, 1, 1, 1};
      logic        wr [4] = '{0, 0, 1, 0};
      logic [1:0]  sz [4] = '{2'b10, 2'b11, 2'b10, 2'b01};
      logic [31:0] ad [4] = '{32'h02, 32'h00, 32'h00, 32'h03};
      for (int i = 0; i < 4; i++) begin
         prev = cpuReadData;
         @(negedge clk);
         cpuRead = rd[i]; cpuWrite = wr[i]; cpuSize = sz[i]; cpuAddr = ad[i];
         #1;
         ntests++;
         if ({stall, memRead, memWrite, accessErr} !== 4'b0) begin
            nfail++;
            $display("FAIL illegal%0d req cycle: ctl=%b want 0000", i,
               {stall, memRead, memWrite, accessErr});
         end
         @(negedge clk);
         cpuRead = 0; cpuWrite = 0;
         #1;
         ntests++;
         if ({accessErr, stall, memRead, memWrite} !== 4'b1000) begin
            nfail++;
            $display("FAIL illegal%0d pulse: ctl=%b want 1000", i,
               {accessErr, stall, memRead, memWrite});
         end
         @(negedge clk);
         #1;
         ntests++;
         if (accessErr !== 1'b0 || cpuReadData !== prev) begin
            nfail++;
            $display("FAIL illegal%0d after: err=%b rd=%h want 0/%h",
               i, accessErr, cpuReadData, prev);
         end
      end
   endtask

   task automatic test_reset_mid();
      int st, lw; logic [31:0] r;
      set_word(3, 32'h1122_3344);
      @(negedge clk);
      cpuWrite = 1; cpuSize = 2'b01; cpuAddr = 32'h0E;
      cpuWriteData = 32'hBEEF; memReady = 1;
      @(negedge clk);
      @(negedge clk);
      memReady = 0; cpuWrite = 0;
      #1;
      ntests++;
      if (memWrite !== 1'b1) begin
         nfail++;
         $display("FAIL rmw_write reached: memWrite=%b want 1", memWrite);
      end
      #1 rst_n = 0;
      #1;
      ntests++;
      if ({cpuReadData, memAddr, memWriteData} !== 96'h0 ||
          {memRead, memWrite, accessErr, stall} !== 4'b0) begin
         nfail++;
         $display("FAIL reset mid: rd=%h ad=%h wd=%h ctl=%b want 0",
            cpuReadData, memAddr, memWriteData,
            {memRead, memWrite, accessErr, stall});
      end
      @(negedge clk);
      rst_n = 1;
      access(0, 1, 2'b10, 0, 32'h08, 32'hDEAD_BEEF, 0, 0, 0, st, lw, r);
      ref_store(2'b10, 32'h08, 32'hDEAD_BEEF);
      ntests++;
      if (mem[2] !== 32'hDEAD_BEEF || st != 2 || proto_bad) begin
         nfail++;
         $display("FAIL sw after reset: mem2=%h st=%0d want deadbeef/2",
            mem[2], st);
      end
   endtask

   task automatic test_random();
      int st, lw, base; logic [31:0] r, ad, wd, ex;
      logic [1:0] sz; logic sg, isrd;
      for (int n = 0; n < 80; n++) begin
         sz = 2'($urandom_range(2));
         sg = 1'($urandom);
         isrd = 1'($urandom);
         ad = 32'($urandom_range(63)) & ~((32'd1 << sz) - 32'd1);
         wd = $urandom;
         ex = ref_load(sz, sg, ad);
         access(isrd, !isrd, sz, sg, ad, wd, -1, 60, n[0], st, lw, r);
         base = (!isrd && sz != 2'b10) ? 3 : 2;
         ntests++;
         if (st != base + lw || proto_bad) begin
            nfail++;
            $display("FAIL rand%0d timing: st=%0d want %0d p=%b",
               n, st, base + lw, proto_bad);
         end
         if (isrd) begin
            ntests++;
            if (r !== ex) begin
               nfail++;
               $display("FAIL rand%0d load sz=%0d a=%h: got %h want %h",
                  n, sz, ad, r, ex);
            end
         end else begin
            ref_store(sz, ad, wd);
         end
      end
   endtask

   task automatic test_mem_image();
      for (int i = 0; i < 16; i++) begin
         ntests++;
         if (mem[i] !== ref_word(i)) begin
            nfail++;
            $display("FAIL image word%0d: got %h want %h",
               i, mem[i], ref_word(i));
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) set_word(i, $urandom);
      test_reset();
      test_word_load();
      test_subword_loads();
      test_sb();
      test_ready_wait();
      test_illegal();
      test_reset_mid();
      test_random();
      test_mem_image();
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator for the MIPS MEM stage. Takes byte-addressed load/store requests (byte, halfword, word; signed or unsigned loads) from the pipeline and drives the word-wide data memory over a request/ready handshake. Performs lane extraction and sign/zero extension on loads, and read-modify-write for sub-word stores. It stalls the pipeline until each access completes.

## Interface

Parameters:
- None. All widths are fixed at 32 bits; memory is word-indexed.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpuRead  in  1  load request from the MEM stage.
- cpuWrite  in  1  store request from the MEM stage.
- cpuSize  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
- cpuSigned  in  1  load extension: 1 sign-extend, 0 zero-extend. Ignored for word and for stores.
- cpuAddr  in  32  byte address.
- cpuWriteData  in  32  store data; byte/half taken from the low bits.
- cpuReadData  out  32  registered load result.
- stall  out  1  holds the pipeline while an access is in progress.
- accessErr  out  1  one-cycle pulse on an illegal request.
- memAddr  out  32  word index, {2'b00, cpuAddr[31:2]}.
- memWriteData  out  32  word to write.
- memRead  out  1  memory read request.
- memWrite  out  1  memory write request.
- memReady  in  1  memory accepts or completes the current request this cycle.
- memReadData  in  32  read word; valid when memReady is high with memRead.

## Operation

- FSM states: IDLE, READ, WRITE, RMW_READ, RMW_WRITE, DONE.
- The request is latched in IDLE: addr, size, signed flag, write data. Changes on cpu* inputs are ignored until the block returns to IDLE.

IDLE:
- A request is illegal if any of these hold:
  - cpuRead and cpuWrite are both high;
  - cpuSize is 11;
  - a half access has cpuAddr[0] set;
  - a word access has cpuAddr[1:0] not equal to 00.
- Illegal request: pulse accessErr high for the next cycle and stay in IDLE. No memory access, stall stays low, cpuReadData is unchanged.
- Legal request goes to:
  - a read → READ;
  - a word store → WRITE;
  - a byte or half store → RMW_READ.

READ and RMW_READ:
- memRead=1 and memAddr are held.
- When memReady=1 at an edge, capture memReadData.
- READ: extract the lane, extend it, and register the result into cpuReadData. Go to DONE.
- RMW_READ: merge the store data into the captured word and store it in memWriteData. Go to RMW_WRITE.

WRITE and RMW_WRITE:
- memWrite=1, with memAddr and memWriteData held.
- When memReady=1 at an edge, go to DONE.

DONE:
- Lasts one cycle with stall=0. The pipeline advances at the end of it.
- Next state is IDLE.

Handshake rules:
- memRead and memWrite are never high together.
- A request stays asserted, with address and data stable, until memReady is sampled high.
- The request deasserts in the cycle after acceptance.

Lane rules (little-endian):
- Byte: lane = addr[1:0], bits [8*lane+7 : 8*lane].
- Half: h = addr[1], bits [16*h+15 : 16*h].
- Loads: sign-extend if cpuSigned, else zero-extend.
- Stores: replace only the addressed lane with cpuWriteData[7:0] (byte) or [15:0] (half). All other bits keep the value read in RMW_READ.

stall (combinational):
- High in IDLE when a legal request is present.
- High in READ, WRITE, RMW_READ and RMW_WRITE.
- Low in DONE, in IDLE with no or illegal request, and while rst_n=0.

## Timing

- Reset values: cpuReadData, memAddr and memWriteData are 0; memRead, memWrite, accessErr and stall are 0; state is IDLE.
- Reset mid-operation: rst_n low immediately drops memRead and memWrite (asynchronous) and abandons the access. An RMW store interrupted after its read writes nothing.
- With memReady tied high:
  - load or word store: stall high for 2 cycles (IDLE, then READ or WRITE), DONE on the 3rd cycle;
  - sub-word store: stall high for 3 cycles.
- Each cycle memReady is low adds one stall cycle.
- cpuReadData changes only on the edge entering DONE from READ, and holds until the next completed load.
- memReady while neither memRead nor memWrite is high is ignored.

## Test plan

1. Word load, memReady=1, word[7]=0x00000015, cpuAddr=0x1C:
   - memAddr=7, memRead high for one cycle;
   - stall high for exactly 2 cycles;
   - cpuReadData=0x00000015 in DONE.
2. Sub-word loads, word[7]=0x123480FF:
   - lb at 0x1D → 0xFFFFFF80;
   - lbu at 0x1D → 0x00000080;
   - lh at 0x1E → 0x00001234.
3. sb at 0x05 with data 0xAB, word[1]=0x00000005:
   - memRead at index 1, then memWrite with 0x0000AB05;
   - stall high for 3 cycles.
4. Word load with memReady held low for 4 cycles:
   - memRead and memAddr stay constant, stall stays high;
   - cpuAddr changes mid-wait have no effect;
   - completes 1 cycle after memReady rises.
5. Illegal requests (lw at 0x02, cpuSize=11, and cpuRead and cpuWrite both high) each produce:
   - a single accessErr pulse;
   - memRead=memWrite=0, stall=0, cpuReadData unchanged.
6. rst_n pulsed low while in RMW_WRITE with memReady=0:
   - memWrite drops immediately and all outputs go to 0;
   - after release, a word store to index 2 completes normally.
